// File: rtl/instr_fetch_unit.sv
// Instruction fetch and sequencing stage.
// Owns the PC, fetches 16-bit words over a req/ack handshake, holds them in IR
// and issues decoded fields downstream with valid/ready. A HALT word stops
// fetching until run is asserted again.
// Optional build macro: FETCH_STATS_EN adds saturating issue/wait counters.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              exec_ready,
    output logic [3:0]        opcode,
    output logic [1:0]        rx,
    output logic [1:0]        ry,
    output logic [7:0]        imm,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_wait
`endif
);

    localparam logic [3:0] OpHalt = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StIssue,
        StHalt
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir_q;
    logic              req_q;
    logic              valid_q;
    logic              halted_q;

    // Sequencing FSM; req/valid/halted are registered alongside the state so
    // no input ever reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q <= StFetch;
                        req_q   <= 1'b1;
                    end
                end
                StFetch: begin
                    if (imem_ack) begin
                        pc_q  <= pc_q + ADDR_W'(1);
                        req_q <= 1'b0;
                        // HALT is consumed here and never reaches IR
                        if (imem_rdata[15:12] == OpHalt) begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end else begin
                            ir_q    <= imem_rdata;
                            state_q <= StIssue;
                            valid_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (exec_ready) begin
                        state_q <= StFetch;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                    end
                end
                StHalt: begin
                    if (run) begin
                        state_q  <= StFetch;
                        halted_q <= 1'b0;
                        req_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Fields are always driven from IR; consumers qualify with instr_valid
    assign opcode      = ir_q[15:12];
    assign rx          = ir_q[11:10];
    assign ry          = ir_q[9:8];
    assign imm         = ir_q[7:0];
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

`ifdef FETCH_STATS_EN
    logic [15:0] stat_issued_q;
    logic [15:0] stat_wait_q;

    // Saturating counters of accepted instructions and memory wait cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_wait_q   <= '0;
        end else begin
            if (valid_q && exec_ready && (stat_issued_q != 16'hFFFF)) begin
                stat_issued_q <= stat_issued_q + 16'd1;
            end
            if ((state_q == StFetch) && !imem_ack && (stat_wait_q != 16'hFFFF)) begin
                stat_wait_q <= stat_wait_q + 16'd1;
            end
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_wait   = stat_wait_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed handshake/halt/wrap/reset steps plus a
// randomized program run checked against a trace computed from the program.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        instr_valid;
    logic        exec_ready = 1'b0;
    logic [3:0]  opcode;
    logic [1:0]  rx;
    logic [1:0]  ry;
    logic [7:0]  imm;
    logic [7:0]  pc;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_wait;
`endif

    logic [15:0] fields;
    assign fields = {opcode, rx, ry, imm};

    int n_chk  = 0;
    int n_fail = 0;

    instr_fetch_unit #(
        .ADDR_W   (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .exec_ready  (exec_ready),
        .opcode      (opcode),
        .rx          (rx),
        .ry          (ry),
        .imm         (imm),
        .pc          (pc),
        .halted      (halted)
`ifdef FETCH_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_wait   (stat_wait)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_fields"}, 32'(fields), 32'd0);
`ifdef FETCH_STATS_EN
        chk({tag, "_stat_issued"}, 32'(stat_issued), 32'd0);
        chk({tag, "_stat_wait"}, 32'(stat_wait), 32'd0);
`endif
    endtask

    logic [15:0] mem [256];
    logic [15:0] exp_q [$];
    logic [15:0] w;
    logic [15:0] ack_word;
    logic [7:0]  exp_addr;
    int          wait_left;
    int          n_wait_cycles;
    int          n_accepts;
    bit          acked;
    bit          reached;

    localparam int ProgLen = 24;

    initial begin
        // Reset with run asserted: run must be ignored
        rst = 1'b1;
        run = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        run = 1'b0;
        chk_reset_outputs("reset");
        tick();
        chk("idle_no_req", 32'(imem_req), 32'd0);

        // Run pulse, zero-wait ADD at address 0
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("run_req", 32'(imem_req), 32'd1);
        chk("run_addr", 32'(imem_addr), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 16'h2105;
        exec_ready = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("add_valid", 32'(instr_valid), 32'd1);
        chk("add_fields", 32'(fields), 32'h2105);
        chk("add_opcode", 32'(opcode), 32'h2);
        chk("add_ry", 32'(ry), 32'h1);
        chk("add_pc", 32'(pc), 32'd1);
        chk("add_req_low", 32'(imem_req), 32'd0);
        tick();
        chk("accept_req", 32'(imem_req), 32'd1);
        chk("accept_addr", 32'(imem_addr), 32'd1);
        chk("accept_valid", 32'(instr_valid), 32'd0);

        // Three wait cycles before ack: request and address must hold
        exec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", 32'(imem_addr), 32'd1);
            chk("wait_valid", 32'(instr_valid), 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = 16'h36AA;
        tick();
        imem_ack = 1'b0;
        chk("xor_valid", 32'(instr_valid), 32'd1);
        chk("xor_fields", 32'(fields), 32'h36AA);
        chk("xor_pc", 32'(pc), 32'd2);
`ifdef FETCH_STATS_EN
        chk("stat_wait_3", 32'(stat_wait), 32'd3);
        chk("stat_issued_1", 32'(stat_issued), 32'd1);
`endif

        // Stall in ISSUE for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_fields", 32'(fields), 32'h36AA);
            chk("stall_no_req", 32'(imem_req), 32'd0);
        end
        exec_ready = 1'b1;
        tick();
        chk("release_req", 32'(imem_req), 32'd1);
        chk("release_addr", 32'(imem_addr), 32'd2);
        chk("release_valid", 32'(instr_valid), 32'd0);

        // LOAD at 2, MOV at 3, HALT at 4
        imem_ack   = 1'b1;
        imem_rdata = 16'h0742;
        tick();
        chk("load_fields", 32'(fields), 32'h0742);
        chk("load_rx", 32'(rx), 32'h1);
        chk("load_ry", 32'(ry), 32'h3);
        imem_ack = 1'b0;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 16'h1000;
        chk("mov_addr", 32'(imem_addr), 32'd3);
        tick();
        imem_ack = 1'b0;
        chk("mov_valid", 32'(instr_valid), 32'd1);
        tick();
        chk("halt_fetch_addr", 32'(imem_addr), 32'd4);
        imem_ack   = 1'b1;
        imem_rdata = 16'hF000;
        tick();
        imem_ack = 1'b0;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd5);
        chk("halt_req", 32'(imem_req), 32'd0);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_ir_kept", 32'(fields), 32'h1000);
        tick();
        tick();
        chk("halt_hold", 32'(halted), 32'd1);
        chk("halt_hold_valid", 32'(instr_valid), 32'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", 32'(imem_addr), 32'd5);
        chk("resume_halted", 32'(halted), 32'd0);

        // Reset mid-request with run asserted
        rst = 1'b1;
        run = 1'b1;
        tick();
        rst = 1'b0;
        run = 1'b0;
        chk_reset_outputs("midreq_rst");
        tick();
        chk("midreq_idle", 32'(imem_req), 32'd0);

        // Random program: ProgLen non-HALT words then HALT, random latency/ready
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'hE;
            mem[i] = w;
        end
        mem[ProgLen] = 16'hF000 | 16'($urandom_range(0, 4095));
        exp_q.delete();
        for (int i = 0; i < ProgLen; i++) exp_q.push_back(mem[i]);
        exp_addr      = 8'd0;
        wait_left     = int'($urandom_range(0, 3));
        n_wait_cycles = 0;
        n_accepts     = 0;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int cyc = 0; cyc < 2000 && !halted; cyc++) begin
            imem_ack   = 1'b0;
            exec_ready = 1'($urandom_range(0, 1));
            acked      = 1'b0;
            if (imem_req) begin
                if (wait_left == 0) begin
                    chk("rnd_fetch_addr", 32'(imem_addr), 32'(exp_addr));
                    imem_ack   = 1'b1;
                    imem_rdata = mem[exp_addr];
                    ack_word   = mem[exp_addr];
                    exp_addr   = exp_addr + 8'd1;
                    wait_left  = int'($urandom_range(0, 3));
                    acked      = 1'b1;
                end else begin
                    wait_left--;
                    n_wait_cycles++;
                    imem_rdata = 16'($urandom);
                end
            end else begin
                imem_rdata = 16'($urandom);
            end
            if (instr_valid && exec_ready) begin
                n_accepts++;
                if (exp_q.size() == 0) begin
                    chk("rnd_extra_issue", 32'(fields), 32'hFFFF_FFFF);
                end else begin
                    chk("rnd_issue_word", 32'(fields), 32'(exp_q.pop_front()));
                end
            end
            tick();
            imem_ack = 1'b0;
            if (acked && ack_word[15:12] != 4'hF) begin
                chk("rnd_valid_after_ack", 32'(instr_valid), 32'd1);
            end
        end
        chk("rnd_halted", 32'(halted), 32'd1);
        chk("rnd_pc", 32'(pc), 32'(ProgLen + 1));
        chk("rnd_remaining", 32'(exp_q.size()), 32'd0);
        chk("rnd_accepts", 32'(n_accepts), 32'(ProgLen));
`ifdef FETCH_STATS_EN
        chk("rnd_stat_issued", 32'(stat_issued), 32'(ProgLen));
        chk("rnd_stat_wait", 32'(stat_wait), 32'(n_wait_cycles));
`endif

        // PC wrap: run from reset with zero-wait NOPs until address FF
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exec_ready = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        reached = 1'b0;
        for (int cyc = 0; cyc < 700 && !reached; cyc++) begin
            imem_ack = 1'b0;
            if (imem_req) begin
                if (imem_addr == 8'hFF) begin
                    reached = 1'b1;
                end else begin
                    imem_ack   = 1'b1;
                    imem_rdata = 16'h4000 | 16'(imem_addr);
                end
            end
            if (!reached) tick();
        end
        chk("wrap_reach", 32'(imem_addr), 32'hFF);
        imem_ack   = 1'b1;
        imem_rdata = 16'h2ABC;
        tick();
        imem_ack = 1'b0;
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_valid", 32'(instr_valid), 32'd1);
        chk("wrap_fields", 32'(fields), 32'h2ABC);
        tick();
        chk("wrap_next_req", 32'(imem_req), 32'd1);
        chk("wrap_next_addr", 32'(imem_addr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
